kgp_mem_arbiter: RTL and testbench

KGP_MEM_ARBITER -- requirements
Module: kgp_mem_arbiter

---
 rtl/kgp_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_kgp_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kgp_mem_arbiter.sv
// Single-port memory arbiter: instruction fetch vs. data load/store, one transaction in flight.
// Optional perf counters are built when KGP_ARB_PERF_EN is defined.
module kgp_mem_arbiter #(
  parameter int unsigned MEM_LAT        = 1,
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wea,
  input  logic [31:0] mem_rdata,
  output logic        cpu_stall
`ifdef KGP_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  typedef enum logic [1:0] {OpFetch, OpLoad, OpStore} op_e;

  localparam logic [3:0] BurstMax = 4'(DATA_BURST_MAX);
  localparam logic [2:0] LatMax   = 3'(MEM_LAT);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [2:0]  lat_q, lat_d;
  logic [3:0]  burst_q, burst_d;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        fetch_win, grant_ok, store_gnt, capture;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpFetch;
      lat_q   <= 3'd0;
      burst_q <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lat_q   <= lat_d;
      burst_q <= burst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lat_d   = lat_q;
    unique case (state_q)
      StIdle: begin
        if (if_gnt) begin
          state_d = StAccess;
          op_d    = OpFetch;
          lat_d   = 3'd1;
        end else if (d_gnt) begin
          state_d = StAccess;
          op_d    = d_we ? OpStore : OpLoad;
          lat_d   = 3'd1;
        end
      end
      StAccess: begin
        if (op_q == OpStore) begin
          state_d = StIdle;
        end else if (lat_q == LatMax) begin
          state_d = StResp;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Burst count only tracks data grants that starved a waiting fetch
    if (!if_req || if_gnt) begin
      burst_d = 4'd0;
    end else if (d_gnt && burst_q != BurstMax) begin
      burst_d = burst_q + 4'd1;
    end else begin
      burst_d = burst_q;
    end
  end

  // Outputs; gated by rst_n so they fall immediately when reset asserts
  always_comb begin
    fetch_win = if_req & (~d_req | (burst_q == BurstMax));
    grant_ok  = rst_n & (state_q == StIdle);
    if_gnt    = grant_ok & fetch_win;
    d_gnt     = grant_ok & d_req & ~fetch_win;
    store_gnt = d_gnt & d_we;
    mem_en    = if_gnt | d_gnt;
    mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : 32'd0);
    mem_wea   = {4{store_gnt}};
    mem_wdata = store_gnt ? d_wdata : 32'd0;
    if_valid  = rst_n & (state_q == StResp) & (op_q == OpFetch);
    d_valid   = rst_n & (((state_q == StAccess) & (op_q == OpStore)) |
                         ((state_q == StResp) & (op_q == OpLoad)));
    cpu_stall = rst_n & (if_req | d_req | (state_q != StIdle)) & ~(if_valid | d_valid);
    capture   = (state_q == StAccess) & (op_q != OpStore) & (lat_q == LatMax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else if (capture) begin
      if (op_q == OpFetch) if_rdata_q <= mem_rdata;
      else                 d_rdata_q  <= mem_rdata;
    end
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

`ifdef KGP_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_grants    <= 32'd0;
      perf_d_grants     <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (if_gnt)    perf_if_grants    <= perf_if_grants + 32'd1;
      if (d_gnt)     perf_d_grants     <= perf_d_grants + 32'd1;
      if (cpu_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kgp_mem_arbiter.sv
// Bench for kgp_mem_arbiter: directed + random traffic against a word-array memory reference.
// Perf counter checks are compiled only with KGP_ARB_PERF_EN.
module tb_kgp_mem_arbiter;

  localparam int unsigned Lat = 1;

  logic        clk, rst_n;
  logic        if_req, if_gnt, if_valid, d_req, d_we, d_gnt, d_valid, mem_en, cpu_stall;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wea;

  logic        b_rst_n, b_if_req, b_if_gnt, b_if_valid, b_d_req, b_d_we, b_d_gnt, b_d_valid;
  logic        b_mem_en, b_cpu_stall;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata, b_s1, b_s2, b_s3;
  logic [3:0]  b_mem_wea;

`ifdef KGP_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_stall_cycles;
  logic [31:0] b_perf_if, b_perf_d, b_perf_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] rd_q;

  kgp_mem_arbiter #(.MEM_LAT(Lat), .DATA_BURST_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wea(mem_wea),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
`ifdef KGP_ARB_PERF_EN
    , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  kgp_mem_arbiter #(.MEM_LAT(3), .DATA_BURST_MAX(4)) dut_lat3 (
    .clk(clk), .rst_n(b_rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_valid(b_if_valid),
    .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_gnt(b_d_gnt),
    .d_valid(b_d_valid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wea(b_mem_wea),
    .mem_rdata(b_mem_rdata), .cpu_stall(b_cpu_stall)
`ifdef KGP_ARB_PERF_EN
    , .perf_if_grants(b_perf_if), .perf_d_grants(b_perf_d), .perf_stall_cycles(b_perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle-latency synchronous RAM for the main instance
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wea == 4'hF) mem[mem_addr[9:2]] <= mem_wdata;
      else                 rd_q <= mem[mem_addr[9:2]];
    end
  end
  assign mem_rdata = rd_q;

  // Three-cycle read pipeline for the MEM_LAT=3 instance; contents are addr ^ 0x5A5A0000
  always @(posedge clk) begin
    b_s1 <= b_mem_en ? (b_mem_addr ^ 32'h5A5A_0000) : b_s1;
    b_s2 <= b_s1;
    b_s3 <= b_s2;
  end
  assign b_mem_rdata = b_s3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt_exclusive", 32'(if_gnt & d_gnt), 32'd0);
      chk("valid_exclusive", 32'(if_valid & d_valid), 32'd0);
      chk("wea_only_on_store_gnt", 32'(mem_wea), (d_gnt && d_we) ? 32'hF : 32'h0);
    end
    if (b_rst_n) chk("b_valid_exclusive", 32'(b_if_valid & b_d_valid), 32'd0);
  end

  // kind: 0 fetch, 1 load, 2 store. Checks grant, latency, data and the reference memory.
  task automatic txn(input int kind, input logic [31:0] a, input logic [31:0] wd);
    int waitc, lat;
    logic g, v;
    @(posedge clk); #1;
    if (kind == 0) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      d_req = 1'b1; d_we = (kind == 2); d_addr = a; d_wdata = wd;
    end
    waitc = 0;
    @(negedge clk);
    g = (kind == 0) ? if_gnt : d_gnt;
    while (!g && waitc < 20) begin
      @(negedge clk);
      waitc++;
      g = (kind == 0) ? if_gnt : d_gnt;
    end
    chk("grant_seen", 32'(g), 32'd1);
    chk("grant_addr", mem_addr, a);
    chk("grant_mem_en", 32'(mem_en), 32'd1);
    if (kind == 2) begin
      chk("store_wea", 32'(mem_wea), 32'hF);
      chk("store_wdata", mem_wdata, wd);
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    lat = 0;
    v = 1'b0;
    while (!v && lat < 10) begin
      @(negedge clk);
      lat++;
      if (kind == 2 && lat == 1) chk("store_wea_one_cycle", 32'(mem_wea), 32'h0);
      v = (kind == 0) ? if_valid : d_valid;
    end
    chk("valid_latency", 32'(lat), (kind == 2) ? 32'd1 : 32'(Lat + 1));
    chk("stall_low_at_valid", 32'(cpu_stall), 32'd0);
    if (kind == 0) begin
      chk("fetch_req_to_valid", 32'(waitc + lat), 32'(Lat + 1));
      chk("fetch_data", if_rdata, ref_mem[a[9:2]]);
    end else if (kind == 1) begin
      chk("load_data", d_rdata, ref_mem[a[9:2]]);
    end else begin
      ref_mem[a[9:2]] = wd;
    end
  endtask

  initial begin
    logic [5:0] seq;
    int ngr, dg, ig, dv, iv, nv;
`ifdef KGP_ARB_PERF_EN
    logic [31:0] p_if, p_d, p_st;
`endif
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    end
    mem[16] = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;

    // Reset with requests held high: every output must stay quiet
    rst_n = 1'b0; b_rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8;
    d_wdata = 32'hFFFF_FFFF;
    b_if_req = 1'b0; b_if_addr = 32'd0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = 32'd0; b_d_wdata = 32'd0;
    #23;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_wea", 32'(mem_wea), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stall", 32'(cpu_stall), 32'd0);

    // Fetch of 0xDEADBEEF at 0x40: grant cycle 0, valid cycle 2
    txn(0, 32'h40, 32'd0);

    // Store then load back
    txn(2, 32'h100, 32'h1234_5678);
    txn(1, 32'h100, 32'd0);

    // Simultaneous fetch and load: data first, fetch at the next idle
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
    dg = -1; ig = -1; dv = -1; iv = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (d_gnt && dg < 0) dg = c;
      if (if_gnt && ig < 0) ig = c;
      if (d_valid && dv < 0) begin
        dv = c;
        chk("dual_load_data", d_rdata, ref_mem[18]);
      end
      if (if_valid && iv < 0) begin
        iv = c;
        chk("dual_fetch_data", if_rdata, ref_mem[17]);
      end
      @(posedge clk); #1;
      if (dg >= 0) d_req = 1'b0;
      if (ig >= 0) if_req = 1'b0;
    end
    chk("dual_d_gnt_cycle", 32'(dg), 32'd0);
    chk("dual_d_valid_cycle", 32'(dv), 32'd2);
    chk("dual_if_gnt_cycle", 32'(ig), 32'd3);
    chk("dual_if_valid_cycle", 32'(iv), 32'd5);

    // Both requesters held: with a burst limit of 2 the order is D,D,I,D,D,I
    if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    seq = 6'd0; ngr = 0;
    for (int c = 0; c < 60 && ngr < 6; c++) begin
      @(negedge clk);
      if (d_gnt)  begin seq = {seq[4:0], 1'b1}; ngr++; end
      if (if_gnt) begin seq = {seq[4:0], 1'b0}; ngr++; end
    end
    chk("burst_grant_count", 32'(ngr), 32'd6);
    chk("burst_grant_order", 32'(seq), 32'(6'b110110));
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);

    // Random single transactions
    for (int n = 0; n < 40; n++) begin
      txn(int'($urandom_range(0, 2)), {22'd0, 8'($urandom_range(0, 31)), 2'b00}, $urandom);
    end

`ifdef KGP_ARB_PERF_EN
    @(negedge clk);
    p_if = perf_if_grants; p_d = perf_d_grants; p_st = perf_stall_cycles;
    txn(0, 32'h10, 32'd0);
    txn(2, 32'h14, 32'hA5A5_0001);
    txn(0, 32'h18, 32'd0);
    txn(2, 32'h1C, 32'hA5A5_0002);
    txn(0, 32'h20, 32'd0);
    chk("perf_if_grants", perf_if_grants - p_if, 32'd3);
    chk("perf_d_grants", perf_d_grants - p_d, 32'd2);
    chk("perf_stall_cycles", perf_stall_cycles - p_st, 32'd8);
`endif

    // MEM_LAT=3 instance: full load, then a load cut by reset mid-access
    @(posedge clk); #1;
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h80;
    @(negedge clk);
    chk("lat3_d_gnt", 32'(b_d_gnt), 32'd1);
    @(posedge clk); #1;
    b_d_req = 1'b0;
    nv = 0;
    while (!b_d_valid && nv < 10) begin
      @(negedge clk);
      nv++;
    end
    chk("lat3_load_latency", 32'(nv), 32'd4);
    chk("lat3_load_data", b_d_rdata, 32'h5A5A_0080);

    @(posedge clk); #1;
    b_d_req = 1'b1; b_d_addr = 32'hC4;
    @(negedge clk);
    chk("lat3_second_gnt", 32'(b_d_gnt), 32'd1);
    @(posedge clk); #1;
    b_d_req = 1'b0;
    @(posedge clk); #1;
    b_d_req = 1'b1;
    b_rst_n = 1'b0;
    #1;
    chk("lat3_rst_d_gnt", 32'(b_d_gnt), 32'd0);
    chk("lat3_rst_d_valid", 32'(b_d_valid), 32'd0);
    chk("lat3_rst_mem_en", 32'(b_mem_en), 32'd0);
    chk("lat3_rst_wea", 32'(b_mem_wea), 32'd0);
    chk("lat3_rst_stall", 32'(b_cpu_stall), 32'd0);
    chk("lat3_rst_d_rdata", b_d_rdata, 32'd0);
    chk("lat3_rst_if_rdata", b_if_rdata, 32'd0);
    chk("lat3_rst_mem_wdata", b_mem_wdata, 32'd0);
    b_d_req = 1'b0;
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b_d_valid || b_if_valid || b_mem_en) nv++;
    end
    chk("lat3_no_activity_after_reset", 32'(nv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
